// File: rtl/ps2_pkg.sv
// Shared PS/2 frame layout and receiver state encoding.
`timescale 1ns/1ps
package ps2_pkg;
   localparam int PS2_FRAME_BITS = 11;
   localparam int BIT_START      = 0;
   localparam int BIT_DATA_LSB   = 1;
   localparam int BIT_DATA_MSB   = 8;
   localparam int BIT_PARITY     = 9;
   localparam int BIT_STOP       = 10;

   typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} rx_state_e;

   // Data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for a raw PS/2 line.
`timescale 1ns/1ps
module ps2_line_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic clr_,
   input  logic line,
   output logic level,
   output logic fall
);
   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          sync1_q, sync1_d, sync2_q, sync2_d;
   logic          level_q, level_d, fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = line;
      sync2_d = sync1_q;
      level_d = level_q;
      fall_d  = 1'b0;
      cnt_d   = '0;
      // Level flips on the FILTER_LEN-th consecutive disagreeing sample.
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_d = sync2_q;
            fall_d  = level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign fall  = fall_q;
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: frame deserialiser, timeout resync, sticky
// error flags and a drop-newest first-word-fall-through byte FIFO.
`timescale 1ns/1ps
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH_LOG2     = 3,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                clr_,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   input  logic                nextdata_,
   input  logic                clr_err,
   output logic [7:0]          data,
   output logic                ready,
   output logic [DEPTH_LOG2:0] count,
   output logic                overflow,
   output logic                parity_err,
   output logic                frame_err
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic clk_lvl, clk_fall, strobe;
   logic dsync1_q, dsync1_d, dsync2_q, dsync2_d;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk   (clk),
      .clr_  (clr_),
      .line  (ps2_clk),
      .level (clk_lvl),
      .fall  (clk_fall)
   );

   assign strobe = clk_fall & ~clk_lvl;

   rx_state_e                 state;
   logic [3:0]                bitcnt_q, bitcnt_d;
   logic [PS2_FRAME_BITS-2:0] frame_q, frame_d;
   logic [TW-1:0]             to_cnt_q, to_cnt_d;
   logic [PS2_FRAME_BITS-1:0] full_frame;
   logic [7:0]                rx_byte;
   logic                      push_req, set_frame, set_par;

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d, parity_err_q, parity_err_d;
   logic                  frame_err_q, frame_err_d;
   logic                  pop, push, full, ovf_set;

   always_comb begin
      dsync1_d   = ps2_data;
      dsync2_d   = dsync1_q;
      state      = (bitcnt_q == 4'd0) ? ST_IDLE : ST_SHIFT;
      full_frame = {dsync2_q, frame_q};
      rx_byte    = full_frame[BIT_DATA_MSB:BIT_DATA_LSB];
      bitcnt_d   = bitcnt_q;
      frame_d    = frame_q;
      to_cnt_d   = '0;
      push_req   = 1'b0;
      set_frame  = 1'b0;
      set_par    = 1'b0;
      if (strobe) begin
         if (bitcnt_q == 4'(BIT_STOP)) begin
            bitcnt_d = 4'd0;
            if (full_frame[BIT_START] || !full_frame[BIT_STOP])
               set_frame = 1'b1;
            else if (!odd_parity_ok(full_frame[BIT_PARITY:BIT_DATA_LSB]))
               set_par = 1'b1;
            else
               push_req = 1'b1;
         end else begin
            frame_d[bitcnt_q] = dsync2_q;
            bitcnt_d          = bitcnt_q + 4'd1;
         end
      end else if (state == ST_SHIFT) begin
         // A stalled device abandons the frame so the next start bit resyncs.
         if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            bitcnt_d  = 4'd0;
            set_frame = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      full    = (count_q == FULL_CNT);
      pop     = ~nextdata_ & (count_q != '0);
      push    = push_req & (~full | pop);
      ovf_set = push_req & full & ~pop;
      w_ptr_d = push ? w_ptr_q + 1'b1 : w_ptr_q;
      r_ptr_d = pop  ? r_ptr_q + 1'b1 : r_ptr_q;
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      overflow_d   = ovf_set   | (overflow_q   & ~clr_err);
      parity_err_d = set_par   | (parity_err_q & ~clr_err);
      frame_err_d  = set_frame | (frame_err_q  & ~clr_err);
   end

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         dsync1_q     <= 1'b1;
         dsync2_q     <= 1'b1;
         bitcnt_q     <= 4'd0;
         frame_q      <= '0;
         to_cnt_q     <= '0;
         w_ptr_q      <= '0;
         r_ptr_q      <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         dsync1_q     <= dsync1_d;
         dsync2_q     <= dsync2_d;
         bitcnt_q     <= bitcnt_d;
         frame_q      <= frame_d;
         to_cnt_q     <= to_cnt_d;
         w_ptr_q      <= w_ptr_d;
         r_ptr_q      <= r_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[w_ptr_q] <= rx_byte;
   end

   assign data       = mem_q[r_ptr_q];
   assign ready      = (count_q != '0);
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
endmodule
